fb_write_addr_gen: RTL and testbench
====================================

# fb_write_addr_gen

Converts the pixel stream from the SPI command decoder into addressed frame-buffer write requests. Latches the CASET/RASET window when RAMWR is issued, walks a cursor through that window pixel by pixel, and computes the linear frame-buffer address. Buffers {address, pixel} pairs in a small FIFO with a valid/ready handshake toward the frame-buffer memory controller. Sits between the SPI slave (upstream, same clock) and the SRAM/SDRAM write port (downstream).

## Interface
- H_RES, 480, panel width in pixels
- V_RES, 272, panel height in pixels
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES
- FIFO_DEPTH, 16, write FIFO entries; power of two, ≥ 2

Ports:
- i_clk  in  1  FPGA internal clock; single clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_inst_data  in  8  last command byte
- i_inst_en_pls  in  1  1-cycle pulse; i_inst_data is valid
- i_col_addr  in  32  XS[31:16], XE[15:0]
- i_row_addr  in  32  YS[31:16], YE[15:0]
- i_pixel_data  in  16  RGB565 pixel
- i_pixel_en_pls  in  1  1-cycle pulse; i_pixel_data is valid
- o_wr_addr  out  ADDR_W  FIFO head address
- o_wr_data  out  16  FIFO head pixel
- o_wr_valid  out  1  FIFO not empty
- i_wr_ready  in  1  downstream accepts head
- o_frame_done  out  1  1-cycle pulse when the window wraps
- o_overflow  out  1  sticky; a pixel was dropped

## Operation
- States: IDLE, LOAD, WRITE.
- IDLE: pixel pulses are discarded without setting o_overflow. An i_inst_en_pls with 0x2C latches XS/XE/YS/YE and enters LOAD.
- Window clamp at latch time: XE=min(XE,H_RES-1), YE=min(YE,V_RES-1). If XS>XE or YS>YE after the clamp, the window is invalid: return to IDLE.
- LOAD (1 cycle): x=XS, y=YS, row_base=YS*H_RES (registered multiply), then WRITE. A pixel pulse arriving in LOAD sets a pending flag and is pushed on the first WRITE cycle.
- WRITE: on each pixel pulse, push {row_base+x, pixel}, then advance the cursor.
  - If x≠XE: x+1.
  - If x=XE and y≠YE: x=XS, y+1, row_base+=H_RES.
  - If x=XE and y=YE: x=XS, y=YS, row_base=YS*H_RES (value saved from LOAD), and pulse o_frame_done.
- Any i_inst_en_pls other than 0x2C in WRITE returns to IDLE. 0x2C in WRITE relatches the window and reloads via LOAD.
- Command 0x01 (SWRESET) in any state: go to IDLE, flush the FIFO, clear o_overflow.
- FIFO behaviour:
  - First-word-fall-through; o_wr_valid=!empty.
  - Pop occurs when o_wr_valid && i_wr_ready.
  - A push while full is rejected even if a pop happens in the same cycle. The pixel is dropped, the cursor still advances, and o_overflow is set.
  - Simultaneous push and pop when not full: count is unchanged.
- Address arithmetic: unsigned, ADDR_W bits; row_base+x never exceeds H_RES*V_RES-1 because of the clamp.

## Timing
- Reset values:
  - State = IDLE, FIFO empty.
  - o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_frame_done=0, o_overflow=0.
  - Cursor and window registers = 0.
- Latency: a pixel pulse in cycle N with the FIFO empty gives o_wr_valid=1 in cycle N+1, with the address and data of that pixel.
- o_frame_done is asserted in the cycle after the pulse of the last pixel, coincident with its FIFO write.
- o_wr_addr and o_wr_data hold while o_wr_valid && !i_wr_ready.
- Reset takes priority over all events, including mid-frame; the FIFO is emptied.
- The upstream block guarantees at least 8 cycles between pulses; no back-pressure toward the upstream block exists.

## Configuration
- FB_WR_ROTATE180_EN defined: the pushed address is H_RES*V_RES-1-(row_base+x), which rotates the panel image 180°.
- FB_WR_ROTATE180_EN undefined: the pushed address is row_base+x.
- Cursor, frame_done and FIFO behaviour are identical in both builds.

## Test plan
- Window X 0..2, Y 0..1, RAMWR, 6 pixels, ready=1 → addresses 0,1,2,480,481,482; o_frame_done on the 6th; a 7th pixel goes to address 0.
- Window XS=10 XE=600, YS=270 YE=300 → clamped to XE=479, YE=271; first address 129610; after 470 pixels the next address is 130090.
- Window with XS=5 XE=3 → no writes, state stays IDLE, o_overflow=0.
- ready=0, 17 pixels with FIFO_DEPTH=16 → 16 entries held, o_overflow=1; raise ready → 16 in-order pops; SWRESET clears o_overflow.
- Command 0x2A mid-frame, then pixel → pixel ignored; a new RAMWR restarts at (XS,YS).
- With FB_WR_ROTATE180_EN, pixel at (0,0) → address 130559.

Source files
------------

// File: rtl/fb_write_addr_gen.sv
// rtl/fb_write_addr_gen.sv - RAMWR window cursor feeding a FWFT frame-buffer write FIFO
// Build option FB_WR_ROTATE180_EN mirrors every pushed address for a 180 degree panel.
module fb_write_addr_gen #(
    parameter int H_RES      = 480,
    parameter int V_RES      = 272,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_inst_data,
    input  logic              i_inst_en_pls,
    input  logic [31:0]       i_col_addr,
    input  logic [31:0]       i_row_addr,
    input  logic [15:0]       i_pixel_data,
    input  logic              i_pixel_en_pls,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic              o_frame_done,
    output logic              o_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [15:0] X_MAX = 16'(H_RES - 1);
    localparam logic [15:0] Y_MAX = 16'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, row_init_q, row_init_d;
    logic              pend_q, pend_d;
    logic [15:0]       pend_pix_q, pend_pix_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic [ADDR_W+15:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    logic              cmd_ramwr, cmd_swreset, cmd_other;
    logic [15:0]       xs_in, xe_in, ys_in, ye_in;
    logic              win_ok;
    logic              push_req, push_ok, pop, fifo_full, fifo_empty;
    logic [15:0]       push_pix;
    logic [ADDR_W-1:0] lin_addr, push_addr;

    assign cmd_ramwr   = i_inst_en_pls && (i_inst_data == CMD_RAMWR);
    assign cmd_swreset = i_inst_en_pls && (i_inst_data == CMD_SWRESET);
    assign cmd_other   = i_inst_en_pls && !cmd_ramwr && !cmd_swreset;

    // Clamp the end coordinates to the panel before the validity test.
    assign xs_in  = i_col_addr[31:16];
    assign xe_in  = (i_col_addr[15:0] > X_MAX) ? X_MAX : i_col_addr[15:0];
    assign ys_in  = i_row_addr[31:16];
    assign ye_in  = (i_row_addr[15:0] > Y_MAX) ? Y_MAX : i_row_addr[15:0];
    assign win_ok = (xs_in <= xe_in) && (ys_in <= ye_in);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = !fifo_empty && i_wr_ready;
    assign push_ok    = push_req && !fifo_full;

    assign lin_addr = row_base_q + ADDR_W'(x_q);
`ifdef FB_WR_ROTATE180_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    assign push_addr = LAST_ADDR - lin_addr;
`else
    assign push_addr = lin_addr;
`endif

    always_comb begin
        state_d      = state_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        row_base_d   = row_base_q;
        row_init_d   = row_init_q;
        pend_d       = pend_q;
        pend_pix_d   = pend_pix_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        push_req     = 1'b0;
        push_pix     = i_pixel_data;

        if (cmd_swreset) begin
            state_d    = S_IDLE;
            pend_d     = 1'b0;
            overflow_d = 1'b0;
        end else if (cmd_ramwr) begin
            xs_d    = xs_in;
            xe_d    = xe_in;
            ys_d    = ys_in;
            ye_d    = ye_in;
            pend_d  = 1'b0;
            state_d = win_ok ? S_LOAD : S_IDLE;
        end else if (cmd_other && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    x_d        = xs_q;
                    y_d        = ys_q;
                    row_base_d = ADDR_W'(ys_q) * ROW_STEP;
                    row_init_d = ADDR_W'(ys_q) * ROW_STEP;
                    state_d    = S_WRITE;
                    // Pixel arriving before the cursor is ready is replayed next cycle.
                    if (i_pixel_en_pls) begin
                        pend_d     = 1'b1;
                        pend_pix_d = i_pixel_data;
                    end
                end
                S_WRITE: begin
                    if (pend_q || i_pixel_en_pls) begin
                        push_req = 1'b1;
                        push_pix = pend_q ? pend_pix_q : i_pixel_data;
                        pend_d   = 1'b0;
                        if (fifo_full) begin
                            overflow_d = 1'b1;
                        end
                        if (x_q != xe_q) begin
                            x_d = x_q + 16'd1;
                        end else if (y_q != ye_q) begin
                            x_d        = xs_q;
                            y_d        = y_q + 16'd1;
                            row_base_d = row_base_q + ROW_STEP;
                        end else begin
                            x_d          = xs_q;
                            y_d          = ys_q;
                            row_base_d   = row_init_q;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (cmd_swreset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            xs_q         <= '0;
            xe_q         <= '0;
            ys_q         <= '0;
            ye_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            row_base_q   <= '0;
            row_init_q   <= '0;
            pend_q       <= 1'b0;
            pend_pix_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_base_q   <= row_base_d;
            row_init_q   <= row_init_d;
            pend_q       <= pend_d;
            pend_pix_q   <= pend_pix_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_addr, push_pix};
        end
    end

    // Head is forced to zero while empty so stale entries never show on the bus.
    assign o_wr_valid   = !fifo_empty;
    assign o_wr_addr    = fifo_empty ? '0 : mem_q[rd_ptr_q][ADDR_W+15:16];
    assign o_wr_data    = fifo_empty ? '0 : mem_q[rd_ptr_q][15:0];
    assign o_frame_done = frame_done_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_fb_write_addr_gen.sv
// tb/tb_fb_write_addr_gen.sv - randomized self-checking bench for fb_write_addr_gen
// Reference model tracks the window cursor and FIFO contents arithmetically.
module tb_fb_write_addr_gen;
    localparam int H_RES      = 480;
    localparam int V_RES      = 272;
    localparam int ADDR_W     = 17;
    localparam int FIFO_DEPTH = 16;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [7:0]        i_inst_data;
    logic              i_inst_en_pls;
    logic [31:0]       i_col_addr;
    logic [31:0]       i_row_addr;
    logic [15:0]       i_pixel_data;
    logic              i_pixel_en_pls;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [15:0]       o_wr_data;
    logic              o_wr_valid;
    logic              i_wr_ready;
    logic              o_frame_done;
    logic              o_overflow;

    fb_write_addr_gen #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_inst_data(i_inst_data), .i_inst_en_pls(i_inst_en_pls),
        .i_col_addr(i_col_addr), .i_row_addr(i_row_addr),
        .i_pixel_data(i_pixel_data), .i_pixel_en_pls(i_pixel_en_pls),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid),
        .i_wr_ready(i_wr_ready), .o_frame_done(o_frame_done), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: active window, cursor, FIFO contents, sticky overflow.
    bit mact;
    int mxs, mxe, mys, mye, mx, my;
    bit movf;
    bit m_done;
    logic [ADDR_W+15:0] mq[$];

    logic              obs_valid, obs_done, obs_ovf;
    logic [ADDR_W+15:0] obs_entry;
    logic              exp_v;
    logic [ADDR_W+15:0] exp_e;

    function automatic int map_addr(input int lin);
`ifdef FB_WR_ROTATE180_EN
        return H_RES * V_RES - 1 - lin;
`else
        return lin;
`endif
    endfunction

    task automatic model_ramwr(input int xs, input int xe, input int ys, input int ye);
        if (xe > H_RES - 1) xe = H_RES - 1;
        if (ye > V_RES - 1) ye = V_RES - 1;
        mact = (xs <= xe) && (ys <= ye);
        mxs = xs; mxe = xe; mys = ys; mye = ye;
        mx = xs; my = ys;
    endtask

    task automatic model_pixel(input logic [15:0] d);
        int a;
        m_done = 1'b0;
        if (!mact) return;
        a = map_addr(my * H_RES + mx);
        if (mq.size() < FIFO_DEPTH) mq.push_back({a[ADDR_W-1:0], d});
        else movf = 1'b1;
        if (mx != mxe) mx++;
        else if (my != mye) begin mx = mxs; my++; end
        else begin mx = mxs; my = mys; m_done = 1'b1; end
    endtask

    task automatic send_cmd(input logic [7:0] c, input int xs, input int xe, input int ys, input int ye);
        @(posedge i_clk); #1;
        i_inst_data   = c;
        i_inst_en_pls = 1'b1;
        i_col_addr    = {xs[15:0], xe[15:0]};
        i_row_addr    = {ys[15:0], ye[15:0]};
        @(posedge i_clk); #1;
        i_inst_en_pls = 1'b0;
        if (c == 8'h2C) model_ramwr(xs, xe, ys, ye);
        else begin
            mact = 1'b0;
            if (c == 8'h01) begin mq.delete(); movf = 1'b0; end
        end
        repeat (8) @(posedge i_clk);
        #1;
    endtask

    // Pulses one pixel and captures outputs in the following cycle.
    task automatic send_pixel(input logic [15:0] d);
        @(posedge i_clk); #1;
        i_pixel_data   = d;
        i_pixel_en_pls = 1'b1;
        @(posedge i_clk); #1;
        i_pixel_en_pls = 1'b0;
        obs_valid = o_wr_valid;
        obs_entry = {o_wr_addr, o_wr_data};
        obs_done  = o_frame_done;
        obs_ovf   = o_overflow;
        model_pixel(d);
        repeat (8) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        mact = 1'b0; movf = 1'b0; mq.delete();
        n_checks++;
        if ({o_wr_valid, o_wr_addr, o_wr_data, o_frame_done, o_overflow} !== '0)
            $display("FAIL reset_outputs: got valid=%b addr=%0d data=%h done=%b ovf=%b, expected all zero",
                     o_wr_valid, o_wr_addr, o_wr_data, o_frame_done, o_overflow);
        else n_pass++;
    endtask

    task automatic test_small_window;
        int tbl[7] = '{0, 1, 2, 480, 481, 482, 0};
        send_cmd(8'h2C, 0, 2, 0, 1);
        for (int i = 0; i < 7; i++) begin
            send_pixel(16'(16'h1000 + i));
            exp_v = (mq.size() != 0);
            exp_e = exp_v ? mq.pop_front() : '0;
            n_checks++;
            if (obs_valid !== 1'b1 || obs_entry[ADDR_W+15:16] !== ADDR_W'(map_addr(tbl[i])) ||
                obs_entry[15:0] !== 16'(16'h1000 + i) || obs_done !== (i == 5))
                $display("FAIL small_window px%0d: got valid=%b addr=%0d data=%h done=%b, expected valid=1 addr=%0d data=%h done=%b",
                         i, obs_valid, obs_entry[ADDR_W+15:16], obs_entry[15:0], obs_done,
                         map_addr(tbl[i]), 16'(16'h1000 + i), (i == 5));
            else n_pass++;
        end
    endtask

    task automatic test_clamp;
        logic [15:0] d;
        send_cmd(8'h2C, 10, 600, 270, 300);
        for (int i = 0; i < 471; i++) begin
            d = 16'($urandom);
            send_pixel(d);
            exp_v = (mq.size() != 0);
            exp_e = exp_v ? mq.pop_front() : '0;
            n_checks++;
            if (obs_valid !== exp_v || obs_done !== m_done || obs_ovf !== movf || (exp_v && obs_entry !== exp_e) ||
                (i == 0 && obs_entry[ADDR_W+15:16] !== ADDR_W'(map_addr(129610))) ||
                (i == 470 && obs_entry[ADDR_W+15:16] !== ADDR_W'(map_addr(130090))))
                $display("FAIL clamp px%0d: got valid=%b entry=%h done=%b ovf=%b, expected valid=%b entry=%h done=%b ovf=%b",
                         i, obs_valid, obs_entry, obs_done, obs_ovf, exp_v, exp_e, m_done, movf);
            else n_pass++;
        end
    endtask

    task automatic test_invalid_window;
        send_cmd(8'h2C, 5, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send_pixel(16'hBEEF);
            n_checks++;
            if (obs_valid !== 1'b0 || obs_ovf !== 1'b0 || mq.size() != 0)
                $display("FAIL invalid_window px%0d: got valid=%b ovf=%b, expected valid=0 ovf=0", i, obs_valid, obs_ovf);
            else n_pass++;
        end
    endtask

    task automatic test_pending;
        logic [15:0] d;
        d = 16'($urandom);
        @(posedge i_clk); #1;
        i_inst_data = 8'h2C; i_inst_en_pls = 1'b1;
        i_col_addr = {16'd7, 16'd8}; i_row_addr = {16'd3, 16'd3};
        @(posedge i_clk); #1;
        i_inst_en_pls = 1'b0;
        model_ramwr(7, 8, 3, 3);
        i_pixel_data = d; i_pixel_en_pls = 1'b1;
        @(posedge i_clk); #1;
        i_pixel_en_pls = 1'b0;
        model_pixel(d);
        n_checks++;
        if (o_wr_valid !== 1'b0)
            $display("FAIL pending_early: got valid=%b, expected valid=0", o_wr_valid);
        else n_pass++;
        @(posedge i_clk); #1;
        exp_e = mq.pop_front();
        n_checks++;
        if (o_wr_valid !== 1'b1 || {o_wr_addr, o_wr_data} !== exp_e || o_wr_addr !== ADDR_W'(map_addr(1447)))
            $display("FAIL pending_push: got valid=%b entry=%h, expected valid=1 entry=%h", o_wr_valid, {o_wr_addr, o_wr_data}, exp_e);
        else n_pass++;
        repeat (8) @(posedge i_clk);
        #1;
    endtask

    task automatic test_abort;
        send_cmd(8'h2C, 20, 23, 100, 100);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) send_cmd(8'h2A, 0, 1, 0, 1);
            if (i == 3) send_cmd(8'h2C, 20, 23, 100, 100);
            send_pixel(16'(16'h2200 + i));
            exp_v = (mq.size() != 0);
            exp_e = exp_v ? mq.pop_front() : '0;
            n_checks++;
            if (obs_valid !== exp_v || obs_done !== m_done || (exp_v && obs_entry !== exp_e) ||
                (i == 3 && obs_entry[ADDR_W+15:16] !== ADDR_W'(map_addr(48020))))
                $display("FAIL abort px%0d: got valid=%b entry=%h, expected valid=%b entry=%h", i, obs_valid, obs_entry, exp_v, exp_e);
            else n_pass++;
        end
    endtask

    task automatic test_overflow;
        send_cmd(8'h2C, 0, 479, 0, 271);
        i_wr_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_pixel(16'($urandom));
            if (i == 15) begin
                n_checks++;
                if (o_overflow !== 1'b0)
                    $display("FAIL overflow_at_16: got ovf=%b, expected ovf=0", o_overflow);
                else n_pass++;
            end
        end
        n_checks++;
        if (o_wr_valid !== 1'b1 || o_overflow !== 1'b1 || movf !== 1'b1 || {o_wr_addr, o_wr_data} !== mq[0])
            $display("FAIL overflow_full: got valid=%b ovf=%b head=%h, expected valid=1 ovf=1 head=%h",
                     o_wr_valid, o_overflow, {o_wr_addr, o_wr_data}, mq[0]);
        else n_pass++;
        i_wr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_e = mq.pop_front();
            n_checks++;
            if (o_wr_valid !== 1'b1 || {o_wr_addr, o_wr_data} !== exp_e)
                $display("FAIL drain%0d: got valid=%b entry=%h, expected valid=1 entry=%h", i, o_wr_valid, {o_wr_addr, o_wr_data}, exp_e);
            else n_pass++;
            @(posedge i_clk); #1;
        end
        n_checks++;
        if (o_wr_valid !== 1'b0)
            $display("FAIL drain_empty: got valid=%b, expected valid=0", o_wr_valid);
        else n_pass++;
        send_pixel(16'h0BAD);
        exp_e = mq.pop_front();
        n_checks++;
        if (obs_valid !== 1'b1 || obs_entry !== exp_e || obs_entry[ADDR_W+15:16] !== ADDR_W'(map_addr(17)))
            $display("FAIL after_drop: got valid=%b entry=%h, expected valid=1 entry=%h", obs_valid, obs_entry, exp_e);
        else n_pass++;
        send_cmd(8'h01, 0, 0, 0, 0);
        n_checks++;
        if (o_overflow !== 1'b0 || o_wr_valid !== 1'b0)
            $display("FAIL swreset: got ovf=%b valid=%b, expected ovf=0 valid=0", o_overflow, o_wr_valid);
        else n_pass++;
    endtask

    task automatic test_random;
        int xs, ys, xe, ye, npx;
        for (int w = 0; w < 8; w++) begin
            xs = $urandom_range(0, 478);
            xe = xs + $urandom_range(0, 4);
            ys = $urandom_range(0, 271);
            ye = ys + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin xe = xs; xs = xs + 1; end
            send_cmd(8'h2C, xs, xe, ys, ye);
            npx = $urandom_range(1, 25);
            for (int i = 0; i < npx; i++) begin
                send_pixel(16'($urandom));
                exp_v = (mq.size() != 0);
                exp_e = exp_v ? mq.pop_front() : '0;
                n_checks++;
                if (obs_valid !== exp_v || obs_done !== m_done || obs_ovf !== movf || (exp_v && obs_entry !== exp_e))
                    $display("FAIL random w%0d px%0d: got valid=%b entry=%h done=%b ovf=%b, expected valid=%b entry=%h done=%b ovf=%b",
                             w, i, obs_valid, obs_entry, obs_done, obs_ovf, exp_v, exp_e, m_done, movf);
                else n_pass++;
            end
        end
    endtask

    task automatic test_midframe_reset;
        send_cmd(8'h2C, 0, 9, 0, 0);
        i_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_pixel(16'h5A5A);
        n_checks++;
        if (o_wr_valid !== 1'b1)
            $display("FAIL pre_reset_fill: got valid=%b, expected valid=1", o_wr_valid);
        else n_pass++;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_wr_ready = 1'b1;
        mq.delete(); mact = 1'b0; movf = 1'b0;
        n_checks++;
        if (o_wr_valid !== 1'b0 || o_overflow !== 1'b0)
            $display("FAIL midframe_reset: got valid=%b ovf=%b, expected valid=0 ovf=0", o_wr_valid, o_overflow);
        else n_pass++;
        send_pixel(16'h1234);
        n_checks++;
        if (obs_valid !== 1'b0)
            $display("FAIL reset_idle_pixel: got valid=%b, expected valid=0", obs_valid);
        else n_pass++;
    endtask

    initial begin
        i_rst = 1'b1;
        i_inst_data = '0; i_inst_en_pls = 1'b0;
        i_col_addr = '0; i_row_addr = '0;
        i_pixel_data = '0; i_pixel_en_pls = 1'b0;
        i_wr_ready = 1'b1;
        test_reset();
        test_small_window();
        test_clamp();
        test_invalid_window();
        test_pending();
        test_abort();
        test_overflow();
        test_random();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
